// File: rtl/mdll_startup_seq.sv
// MDLL bring-up sequencer: timed RST/OSC/INJ phases, then bang-bang lock
// detection over back-to-back windows with sticky lock-loss and timeout flags.
module mdll_startup_seq (
  input  logic       clk,
  input  logic       rstb,
  input  logic       en,
  input  logic [7:0] settle,
  input  logic [5:0] lock_win,
  input  logic [3:0] lock_tol,
  input  logic       dout_bb,
  output logic       reset_core,
  output logic       en_osc,
  output logic       en_inj,
  output logic       en_ext_tune,
  output logic       en_loop,
  output logic       locked,
  output logic       lock_lost,
  output logic       timeout,
  output logic [2:0] state
);

  localparam int unsigned SettleW = 8;
  localparam int unsigned WinW    = 6;
  localparam int unsigned TolW    = 4;
  localparam int unsigned OnesW   = 7;
  localparam int unsigned CmpW    = 8;
  localparam int unsigned GoodW   = 3;
  localparam int unsigned WcntW   = 8;

  localparam logic [GoodW-1:0] GoodToLock = GoodW'(4);
  localparam logic [WcntW-1:0] WcntMax    = '1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RST    = 3'd1,
    ST_OSC    = 3'd2,
    ST_INJ    = 3'd3,
    ST_TRACK  = 3'd4,
    ST_LOCKED = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic [SettleW-1:0] dwell_q, dwell_d;
  logic [SettleW-1:0] settle_q, settle_d;
  logic [WinW-1:0]    win_q, win_d;
  logic [TolW-1:0]    tol_q, tol_d;
  logic [WinW-1:0]    pos_q, pos_d;
  logic [OnesW-1:0]   ones_q, ones_d;
  logic [GoodW-1:0]   good_q, good_d;
  logic [WcntW-1:0]   wcnt_q, wcnt_d;
  logic               lock_lost_q, lock_lost_d;
  logic               timeout_q, timeout_d;
  logic               reset_core_q, reset_core_d;
  logic               en_osc_q, en_osc_d;
  logic               en_inj_q, en_inj_d;
  logic               en_ext_tune_q, en_ext_tune_d;
  logic               en_loop_q, en_loop_d;
  logic               locked_q, locked_d;

  logic [OnesW-1:0]   ones_tot_c;
  logic [CmpW-1:0]    twice_c;
  logic [CmpW-1:0]    n_c;
  logic [CmpW-1:0]    diff_c;
  logic               good_c;
  logic               win_done_c;

  // Window evaluation: |2*ones - N| <= tol, including the sample taken this cycle.
  always_comb begin
    ones_tot_c = ones_q + OnesW'(dout_bb);
    twice_c    = {ones_tot_c, 1'b0};
    n_c        = CmpW'(win_q) + CmpW'(1);
    diff_c     = (twice_c >= n_c) ? (twice_c - n_c) : (n_c - twice_c);
    good_c     = (diff_c <= CmpW'(tol_q));
    win_done_c = (pos_q == win_q);
  end

  // Next-state and registered-output decode.
  always_comb begin
    state_d       = state_q;
    dwell_d       = dwell_q;
    settle_d      = settle_q;
    win_d         = win_q;
    tol_d         = tol_q;
    pos_d         = pos_q;
    ones_d        = ones_q;
    good_d        = good_q;
    wcnt_d        = wcnt_q;
    lock_lost_d   = lock_lost_q;
    timeout_d     = timeout_q;
    reset_core_d  = 1'b0;
    en_osc_d      = 1'b0;
    en_inj_d      = 1'b0;
    en_ext_tune_d = 1'b0;
    en_loop_d     = 1'b0;
    locked_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d     = ST_RST;
          dwell_d     = '0;
          settle_d    = settle;
          win_d       = lock_win;
          tol_d       = lock_tol;
          lock_lost_d = 1'b0;
          timeout_d   = 1'b0;
        end
      end
      ST_RST, ST_OSC, ST_INJ: begin
        if (dwell_q == settle_q) begin
          dwell_d = '0;
          case (state_q)
            ST_RST:  state_d = ST_OSC;
            ST_OSC:  state_d = ST_INJ;
            default: begin
              state_d = ST_TRACK;
              pos_d   = '0;
              ones_d  = '0;
              good_d  = '0;
              wcnt_d  = '0;
            end
          endcase
        end else begin
          dwell_d = dwell_q + SettleW'(1);
        end
      end
      ST_TRACK: begin
        pos_d  = pos_q + WinW'(1);
        ones_d = ones_tot_c;
        if (win_done_c) begin
          pos_d  = '0;
          ones_d = '0;
          if (good_c && (good_q == GoodToLock - GoodW'(1))) begin
            state_d = ST_LOCKED;
            good_d  = GoodToLock;
          end else begin
            good_d = good_c ? (good_q + GoodW'(1)) : '0;
            if (wcnt_q != WcntMax) begin
              wcnt_d = wcnt_q + WcntW'(1);
            end
            if (wcnt_d == WcntMax) begin
              timeout_d = 1'b1;
            end
          end
        end
      end
      ST_LOCKED: begin
        pos_d  = pos_q + WinW'(1);
        ones_d = ones_tot_c;
        if (win_done_c) begin
          pos_d  = '0;
          ones_d = '0;
          if (!good_c) begin
            state_d     = ST_TRACK;
            lock_lost_d = 1'b1;
            good_d      = '0;
            wcnt_d      = '0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Dropping enable overrides everything, including a window completing now.
    if (!en) begin
      state_d = ST_IDLE;
      dwell_d = '0;
      pos_d   = '0;
      ones_d  = '0;
      good_d  = '0;
      wcnt_d  = '0;
    end

    reset_core_d  = (state_d == ST_IDLE) || (state_d == ST_RST);
    en_osc_d      = (state_d == ST_OSC) || (state_d == ST_INJ) ||
                    (state_d == ST_TRACK) || (state_d == ST_LOCKED);
    en_inj_d      = (state_d == ST_INJ) || (state_d == ST_TRACK) || (state_d == ST_LOCKED);
    en_ext_tune_d = (state_d == ST_OSC) || (state_d == ST_INJ);
    en_loop_d     = (state_d == ST_TRACK) || (state_d == ST_LOCKED);
    locked_d      = (state_d == ST_LOCKED);
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q       <= ST_IDLE;
      dwell_q       <= '0;
      settle_q      <= '0;
      win_q         <= '0;
      tol_q         <= '0;
      pos_q         <= '0;
      ones_q        <= '0;
      good_q        <= '0;
      wcnt_q        <= '0;
      lock_lost_q   <= 1'b0;
      timeout_q     <= 1'b0;
      reset_core_q  <= 1'b1;
      en_osc_q      <= 1'b0;
      en_inj_q      <= 1'b0;
      en_ext_tune_q <= 1'b0;
      en_loop_q     <= 1'b0;
      locked_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      dwell_q       <= dwell_d;
      settle_q      <= settle_d;
      win_q         <= win_d;
      tol_q         <= tol_d;
      pos_q         <= pos_d;
      ones_q        <= ones_d;
      good_q        <= good_d;
      wcnt_q        <= wcnt_d;
      lock_lost_q   <= lock_lost_d;
      timeout_q     <= timeout_d;
      reset_core_q  <= reset_core_d;
      en_osc_q      <= en_osc_d;
      en_inj_q      <= en_inj_d;
      en_ext_tune_q <= en_ext_tune_d;
      en_loop_q     <= en_loop_d;
      locked_q      <= locked_d;
    end
  end

  assign state       = state_q;
  assign reset_core  = reset_core_q;
  assign en_osc      = en_osc_q;
  assign en_inj      = en_inj_q;
  assign en_ext_tune = en_ext_tune_q;
  assign en_loop     = en_loop_q;
  assign locked      = locked_q;
  assign lock_lost   = lock_lost_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_mdll_startup_seq.sv
// Scoreboard bench for mdll_startup_seq: a phase/window reference model pushes
// expected outputs per event; an independent monitor pops and compares.
module tb_mdll_startup_seq;

  logic       clk = 1'b0;
  logic       rstb;
  logic       en;
  logic [7:0] settle;
  logic [5:0] lock_win;
  logic [3:0] lock_tol;
  logic       dout_bb;
  logic       reset_core, en_osc, en_inj, en_ext_tune, en_loop;
  logic       locked, lock_lost, timeout;
  logic [2:0] state;

  mdll_startup_seq dut (
    .clk(clk), .rstb(rstb), .en(en), .settle(settle), .lock_win(lock_win),
    .lock_tol(lock_tol), .dout_bb(dout_bb), .reset_core(reset_core),
    .en_osc(en_osc), .en_inj(en_inj), .en_ext_tune(en_ext_tune),
    .en_loop(en_loop), .locked(locked), .lock_lost(lock_lost),
    .timeout(timeout), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic rc, osc, inj, ext, lp, lk, lost, to;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   started  = 1'b0;

  localparam int M_ALT = 0, M_ONE = 1, M_K = 2, M_RAND = 3;

  // Reference model: elapsed-time phases and an explicit list of window samples.
  int  m_state, m_t, m_settle, m_n, m_tol, m_good, m_wins;
  bit  m_active, m_lost, m_to;
  int  m_win[$];
  bit  alt = 1'b0;

  function automatic void model_reset();
    m_state = 0; m_active = 1'b0; m_t = 0;
    m_settle = 0; m_n = 0; m_tol = 0;
    m_win.delete(); m_good = 0; m_wins = 0;
    m_lost = 1'b0; m_to = 1'b0;
  endfunction

  function automatic void model_step(input bit e, input int s, input int lw, input int lt, input bit d);
    int ones, v;
    bit good;
    if (!e) begin
      m_state = 0; m_active = 1'b0; m_win.delete(); m_good = 0; m_wins = 0;
      return;
    end
    if (!m_active) begin
      m_active = 1'b1; m_settle = s + 1; m_n = lw + 1; m_tol = lt;
      m_lost = 1'b0; m_to = 1'b0; m_t = 0; m_state = 1;
      return;
    end
    if (m_state >= 1 && m_state <= 3) begin
      m_t++;
      if (m_t < m_settle) m_state = 1;
      else if (m_t < 2 * m_settle) m_state = 2;
      else if (m_t < 3 * m_settle) m_state = 3;
      else begin
        m_state = 4; m_win.delete(); m_good = 0; m_wins = 0;
      end
    end else begin
      m_win.push_back(int'(d));
      if (m_win.size() == m_n) begin
        ones = 0;
        foreach (m_win[i]) ones += m_win[i];
        v = 2 * ones - m_n;
        if (v < 0) v = -v;
        good = (v <= m_tol);
        m_win.delete();
        if (m_state == 4) begin
          m_good = good ? m_good + 1 : 0;
          if (m_good == 4) m_state = 5;
          else begin
            m_wins++;
            if (m_wins >= 255) m_to = 1'b1;
          end
        end else if (!good) begin
          m_state = 4; m_lost = 1'b1; m_good = 0; m_wins = 0;
        end
      end
    end
  endfunction

  function automatic exp_t exp_of();
    exp_t x;
    x.st   = 3'(m_state);
    x.rc   = (m_state <= 1);
    x.osc  = (m_state >= 2);
    x.inj  = (m_state >= 3);
    x.ext  = (m_state == 2 || m_state == 3);
    x.lp   = (m_state >= 4);
    x.lk   = (m_state == 5);
    x.lost = m_lost;
    x.to   = m_to;
    return x;
  endfunction

  function automatic logic gen(input int mode, input int k);
    case (mode)
      M_ALT:   begin alt = ~alt; return alt; end
      M_ONE:   return 1'b1;
      M_K:     return (m_win.size() < k);
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  // One clock: drive at the falling edge, predict the next rising edge.
  task automatic cyc(input logic e, input logic d);
    en = e;
    dout_bb = d;
    if (!rstb) model_reset();
    else model_step(e, int'(settle), int'(lock_win), int'(lock_tol), d);
    exp_q.push_back(exp_of());
    @(negedge clk);
  endtask

  // Asynchronous reset mid-cycle: outputs must change without a clock edge.
  task automatic rst_pulse();
    rstb = 1'b0;
    model_reset();
    exp_q.push_back(exp_of());
    cyc(1'b1, 1'b0);
    rstb = 1'b1;
  endtask

  task automatic run_until(input int target, input int budget, input int mode, input int k);
    int n = 0;
    while (m_state != target && n < budget) begin
      cyc(1'b1, gen(mode, k));
      n++;
    end
    if (m_state != target) begin
      n_checks++;
      $display("FAIL wait_state: reached %0d, required %0d within %0d cycles", m_state, target, budget);
    end
  endtask

  // Monitor: compare on every rising clock and on every reset assertion.
  initial begin
    exp_t e, got;
    wait (started);
    forever begin
      @(posedge clk or negedge rstb);
      #1;
      n_checks++;
      got = {state, reset_core, en_osc, en_inj, en_ext_tune, en_loop, locked, lock_lost, timeout};
      if (exp_q.size() == 0) begin
        $display("FAIL scoreboard_empty t=%0t: got %b, required an expectation", $time, got);
      end else begin
        e = exp_q.pop_front();
        if (got === e) n_pass++;
        else $display("FAIL outputs t=%0t {st,rc,osc,inj,ext,loop,lk,lost,to}: got %b required %b",
                      $time, got, e);
      end
    end
  end

  initial begin
    int mode, k;
    rstb = 1'b0; en = 1'b0; settle = '0; lock_win = '0; lock_tol = '0; dout_bb = 1'b0;
    model_reset();
    @(negedge clk);
    started = 1'b1;
    repeat (3) cyc(1'b1, 1'b0);
    rstb = 1'b1;
    repeat (2) cyc(1'b0, 1'b0);

    // Bring-up with settle=3, then lock with alternating detector output.
    settle = 8'd3; lock_win = 6'd15; lock_tol = 4'd2;
    run_until(5, 200, M_ALT, 0);
    repeat (20) cyc(1'b1, gen(M_ALT, 0));
    settle = 8'd200; lock_win = 6'd0; lock_tol = 4'd15;

    // Loss of lock, relock with sticky flag, cleared only by en low/high.
    run_until(4, 40, M_ONE, 0);
    run_until(5, 200, M_ALT, 0);
    repeat (4) cyc(1'b1, gen(M_ALT, 0));
    repeat (2) cyc(1'b0, 1'b0);
    settle = 8'd3; lock_win = 6'd15; lock_tol = 4'd2;
    repeat (8) cyc(1'b1, 1'b0);

    // Abort from INJ.
    cyc(1'b0, 1'b0);
    run_until(3, 50, M_ALT, 0);
    cyc(1'b1, 1'b0);
    repeat (2) cyc(1'b0, 1'b0);

    // Timeout with N=1, tol=0, constant ones.
    settle = 8'd1; lock_win = 6'd0; lock_tol = 4'd0;
    run_until(4, 50, M_ONE, 0);
    repeat (260) cyc(1'b1, 1'b1);
    cyc(1'b0, 1'b0);

    // Tolerance boundary: 9 of 16 with tol=2 is good; then async reset in LOCKED.
    settle = 8'd0; lock_win = 6'd15; lock_tol = 4'd2;
    run_until(5, 100, M_K, 9);
    repeat (5) cyc(1'b1, gen(M_K, 9));
    rst_pulse();
    repeat (3) cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);

    // 10 of 16 with tol=3 is bad: must stay in TRACK.
    lock_tol = 4'd3;
    repeat (120) cyc(1'b1, gen(M_K, 10));
    cyc(1'b0, 1'b0);

    // Randomized runs with random capture values and disturbances.
    for (int r = 0; r < 14; r++) begin
      settle   = 8'($urandom_range(0, 6));
      lock_win = 6'($urandom_range(0, 15));
      lock_tol = 4'($urandom_range(0, 4));
      mode     = $urandom_range(0, 3);
      k        = (int'(lock_win) + 1) / 2 + $urandom_range(0, 1);
      cyc(1'b0, 1'b0);
      for (int i = 0; i < 180; i++) begin
        if ($urandom_range(0, 199) == 0) cyc(1'b0, 1'b0);
        else if ($urandom_range(0, 299) == 0) rst_pulse();
        else begin
          if (i == 40) begin
            settle = 8'($urandom); lock_win = 6'($urandom); lock_tol = 4'($urandom);
          end
          cyc(1'b1, gen(mode, k));
        end
      end
    end

    cyc(1'b0, 1'b0);
    #2;
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL leftover: %0d expectations unconsumed, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mdll_startup_seq.md
MDLL_STARTUP_SEQ -- requirements
Module: mdll_startup_seq

Interface
REQ-001 SHALL provide port clk, input, 1 bit: sequencer clock (divided reference clock); all state changes on its rising edge.
REQ-002 SHALL provide port rstb, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL provide port en, input, 1 bit: level enable; high starts or continues the bring-up sequence; low returns the block to IDLE.
REQ-004 SHALL provide port settle, input, 8 bits: dwell per timed state, giving settle+1 cycles.
REQ-005 SHALL provide port lock_win, input, 6 bits: lock window length, giving N=lock_win+1 cycles.
REQ-006 SHALL provide port lock_tol, input, 4 bits: allowed bang-bang imbalance.
REQ-007 SHALL provide port dout_bb, input, 1 bit: bang-bang phase detector output, synchronous to clk.
REQ-008 SHALL provide port reset_core, output, 1 bit: core/loop reset, active-high.
REQ-009 SHALL provide port en_osc, output, 1 bit: main oscillator enable.
REQ-010 SHALL provide port en_inj, output, 1 bit: injection enable.
REQ-011 SHALL provide port en_ext_tune, output, 1 bit: external mtune preload enable.
REQ-012 SHALL provide port en_loop, output, 1 bit: tracking loop enable.
REQ-013 SHALL provide port locked, output, 1 bit: lock indication.
REQ-014 SHALL provide port lock_lost, output, 1 bit: sticky flag, set on loss of lock.
REQ-015 SHALL provide port timeout, output, 1 bit: sticky flag, set when lock is not reached.
REQ-016 SHALL provide port state, output, 3 bits: current state encoding.

Function
REQ-017 SHALL implement the states IDLE=0, RST=1, OSC=2, INJ=3, TRACK=4 and LOCKED=5; codes 6 and 7 SHALL go to IDLE on the next cycle.
REQ-018 SHALL drive the outputs per state as follows: IDLE gives reset_core=1 and all enables 0; RST gives reset_core=1; OSC gives en_osc=1 and en_ext_tune=1; INJ gives en_osc=1, en_inj=1 and en_ext_tune=1; TRACK and LOCKED give en_osc=1, en_inj=1, en_loop=1 and en_ext_tune=0. All outputs SHALL be registered.
REQ-019 SHALL move from IDLE to RST on the cycle en is sampled high, and capture settle, lock_win and lock_tol into internal registers on that cycle; the registered values SHALL be used until the next IDLE exit.
REQ-020 SHALL dwell exactly settle+1 cycles in each of RST, OSC and INJ, then advance RST to OSC, OSC to INJ and INJ to TRACK; settle=0 SHALL give 1 cycle per state.
REQ-021 SHALL, in TRACK and LOCKED, count the cycles with dout_bb=1 over consecutive N-cycle windows using a 7-bit count.
REQ-022 SHALL mark a window good when |2*ones - N| <= lock_tol, evaluated at 8-bit width.
REQ-023 SHALL open the first window on the cycle after TRACK is entered; windows SHALL be back-to-back with no gap.
REQ-024 SHALL move TRACK to LOCKED after 4 consecutive good windows; a bad window SHALL reset the good-window count to 0.
REQ-025 SHALL assert locked in the same cycle the state enters LOCKED.
REQ-026 SHALL, on a bad window in LOCKED, move to TRACK on the next cycle, deassert locked, set lock_lost and restart the good-window count.
REQ-027 SHALL set timeout and remain in TRACK when 255 windows complete in TRACK without reaching LOCKED; the 8-bit window counter SHALL saturate and SHALL clear on each TRACK entry.
REQ-028 SHALL move to IDLE on the next cycle from any state when en=0; this SHALL take priority over every other transition.
REQ-029 SHALL clear lock_lost and timeout only on IDLE exit or on reset.
REQ-030 SHALL, when a window completes on the same cycle en falls, act on en falling and discard the window.

Reset
REQ-031 SHALL, when rstb=0, immediately force state=IDLE, reset_core=1, all enables 0, locked=0, lock_lost=0, timeout=0, and all counters and captured configuration to 0.
REQ-032 SHALL, after rstb rises, leave IDLE only on a rising clk edge where en=1.
REQ-033 SHALL, on reset asserted in mid-sequence, abort the sequence with no partial output state retained.

Verification
REQ-034 SHALL cover basic bring-up: settle=3, en=1 held -> RST, OSC and INJ each last 4 cycles and TRACK is entered on cycle 13 after en.
REQ-035 SHALL cover lock acquisition: lock_win=15, lock_tol=2, dout_bb alternating 1/0 -> locked=1 exactly after 4 windows (64 cycles) in TRACK.
REQ-036 SHALL cover loss of lock: while LOCKED, dout_bb held 1 for a full window -> TRACK next cycle, locked=0, lock_lost=1 and sticky until en toggles low then high.
REQ-037 SHALL cover timeout: dout_bb=1 constant, lock_win=0, lock_tol=0 -> timeout=1 after 255 cycles in TRACK, with state remaining 4.
REQ-038 SHALL cover abort: en dropped in INJ -> IDLE next cycle; rstb pulsed low in LOCKED -> immediate IDLE outputs with no clock edge.
REQ-039 SHALL cover tolerance boundary: N=16, ones=9 with lock_tol=2 counts as good; ones=10 with lock_tol=3 counts as bad.
